// File: rtl/pipe_ctrl_pkg.sv
// Shared exception codes, vector offsets, FSM encoding and stage-mask helper for pipe_ctrl_gen.
// Pure declarations: no latency, no backpressure.
package pipe_ctrl_pkg;

    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_INV  = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_TR   = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    localparam logic [11:0] VEC_INT = 12'h020;
    localparam logic [11:0] VEC_GEN = 12'h040;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // Stages 0..pos all held: the requester freezes everything upstream of itself.
    function automatic logic [31:0] stage_mask(input int unsigned pos);
        return (32'd1 << (pos + 32'd1)) - 32'd1;
    endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Counts consecutive active cycles (saturating) and raises a registered timeout once the count hits STALL_MAX.
// Timeout follows the count by one cycle; no backpressure.
module stall_watchdog #(
    parameter int STALL_MAX = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    output logic timeout
);

    localparam int                CNT_W   = $clog2(STALL_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STALL_MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    always_comb begin
        cnt_d = '0;
        if (active) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
        timeout_d = (cnt_q == CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;

endmodule

// File: rtl/pipe_ctrl_gen.sv
// Pipeline controller: merges stall requests into a per-stage stall vector and turns MEM exceptions into redirect+flush.
// Stall is combinational; redirect/flush register one cycle after the code; codes arriving during a flush are dropped.
module pipe_ctrl_gen
    import pipe_ctrl_pkg::*;
#(
    parameter int                    NSTAGE       = 6,
    parameter int                    NREQ         = 2,
    parameter int                    POS_W        = 3,
    parameter logic [NREQ*POS_W-1:0] STALL_POS    = {3'd3, 3'd2},
    parameter int                    FLUSH_CYCLES = 1,
    parameter int                    STALL_MAX    = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   stallreq_i,
    input  logic [31:0]       excepttype_i,
    input  logic [31:0]       cp0_epc_i,
    input  logic [31:0]       ebase_i,
    output logic [NSTAGE-1:0] stall_o,
    output logic              flush_o,
    output logic              pc_redirect_o,
    output logic [31:0]       new_pc_o,
    output logic              stall_timeout_o
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic        flush_q, flush_d;
    logic        redirect_q, redirect_d;
    logic [31:0] new_pc_q, new_pc_d;

    logic [NSTAGE-1:0] stall_merge;
    logic              exc_vld;
    logic [31:0]       exc_target;
    logic              accept;
    logic              unused_ebase;

    assign unused_ebase = ^ebase_i[11:0];

    always_comb begin
        stall_merge = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (stallreq_i[i]) begin
                stall_merge = stall_merge
                            | NSTAGE'(stage_mask(int'(STALL_POS[i*POS_W +: POS_W])));
            end
        end
    end

    always_comb begin
        exc_vld    = 1'b1;
        exc_target = {ebase_i[31:12], VEC_GEN};
        case (excepttype_i)
            EXC_INT:                         exc_target = {ebase_i[31:12], VEC_INT};
            EXC_SYS, EXC_INV, EXC_OV, EXC_TR: exc_target = {ebase_i[31:12], VEC_GEN};
            EXC_ERET:                        exc_target = cp0_epc_i;
            default:                         exc_vld    = 1'b0;
        endcase
    end

    assign accept = (state_q == ST_RUN) && exc_vld;

    // Stalls are dropped while a redirect is pending so the flush is never held off.
    assign stall_o = (!rst_n || state_q == ST_FLUSH || accept) ? '0 : stall_merge;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        flush_d     = flush_q;
        redirect_d  = 1'b0;
        new_pc_d    = new_pc_q;
        case (state_q)
            ST_RUN: begin
                if (exc_vld) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                    flush_d     = 1'b1;
                    redirect_d  = 1'b1;
                    new_pc_d    = exc_target;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                    flush_d = 1'b0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                flush_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= 4'd0;
            flush_q     <= 1'b0;
            redirect_q  <= 1'b0;
            new_pc_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            flush_q     <= flush_d;
            redirect_q  <= redirect_d;
            new_pc_q    <= new_pc_d;
        end
    end

    assign flush_o       = flush_q;
    assign pc_redirect_o = redirect_q;
    assign new_pc_o      = new_pc_q;

    stall_watchdog #(
        .STALL_MAX (STALL_MAX)
    ) u_stall_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .active  (|stall_o),
        .timeout (stall_timeout_o)
    );

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Bench for pipe_ctrl_gen: two instances (3-cycle and 1-cycle flush) share stimulus and are compared every cycle
// against a behavioural model, with directed steps followed by randomized traffic.
module tb_pipe_ctrl_gen;

    localparam int SMAX = 255;
    localparam int POS [2] = '{2, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [1:0]        stallreq;
    logic [31:0]       code, epc, ebase;
    logic [1:0][5:0]   st;
    logic [1:0]        fl, rd, to;
    logic [1:0][31:0]  pc;

    pipe_ctrl_gen #(.FLUSH_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .stallreq_i(stallreq), .excepttype_i(code),
        .cp0_epc_i(epc), .ebase_i(ebase), .stall_o(st[0]), .flush_o(fl[0]),
        .pc_redirect_o(rd[0]), .new_pc_o(pc[0]), .stall_timeout_o(to[0])
    );

    pipe_ctrl_gen u_dut1 (
        .clk(clk), .rst_n(rst_n), .stallreq_i(stallreq), .excepttype_i(code),
        .cp0_epc_i(epc), .ebase_i(ebase), .stall_o(st[1]), .flush_o(fl[1]),
        .pc_redirect_o(rd[1]), .new_pc_o(pc[1]), .stall_timeout_o(to[1])
    );

    int          checks = 0;
    int          errors = 0;
    int          flen   [2] = '{3, 1};
    int          m_busy [2];
    bit          m_redir[2];
    logic [31:0] m_pc   [2];
    int          m_run  [2];
    bit          m_to   [2];
    logic [31:0] valid_codes [6] = '{32'h01, 32'h08, 32'h0a, 32'h0c, 32'h0d, 32'h0e};

    function automatic bit is_valid(input logic [31:0] c);
        return c inside {32'h01, 32'h08, 32'h0a, 32'h0c, 32'h0d, 32'h0e};
    endfunction

    function automatic logic [31:0] target(input logic [31:0] c, input logic [31:0] e, input logic [31:0] base);
        if (c == 32'h0e) return e;
        return (base & 32'hffff_f000) + ((c == 32'h01) ? 32'h20 : 32'h40);
    endfunction

    // Every stage up to the deepest requested one is held.
    function automatic logic [5:0] merged(input logic [1:0] r);
        int deep = -1;
        for (int i = 0; i < 2; i++) if (r[i] && POS[i] > deep) deep = POS[i];
        if (deep < 0) return 6'd0;
        return 6'((1 << (deep + 1)) - 1);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_redir[k] = 0; m_pc[k] = 32'd0; m_run[k] = 0; m_to[k] = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare all outputs of both instances, then advance the model across the coming edge.
    task automatic cycle();
        logic [5:0] es [2];
        #1;
        if (!rst_n) model_reset();
        for (int k = 0; k < 2; k++) begin
            es[k] = (!rst_n || m_busy[k] > 0 || is_valid(code)) ? 6'd0 : merged(stallreq);
            chk($sformatf("stall[%0d]", k),    st[k], es[k]);
            chk($sformatf("flush[%0d]", k),    fl[k], m_busy[k] > 0);
            chk($sformatf("redirect[%0d]", k), rd[k], m_redir[k]);
            chk($sformatf("new_pc[%0d]", k),   pc[k], m_pc[k]);
            chk($sformatf("timeout[%0d]", k),  to[k], m_to[k]);
        end
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_to[k]  = (m_run[k] >= SMAX);
                m_run[k] = (es[k] != 6'd0) ? m_run[k] + 1 : 0;
                if (m_busy[k] > 0) begin
                    m_busy[k]--; m_redir[k] = 0;
                end else if (is_valid(code)) begin
                    m_busy[k] = flen[k]; m_redir[k] = 1; m_pc[k] = target(code, epc, ebase);
                end else begin
                    m_redir[k] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cycle();
        int r;
        r        = $urandom_range(0, 11);
        stallreq = 2'($urandom_range(0, 3));
        epc      = $urandom;
        ebase    = $urandom;
        if (r < 6)       code = 32'd0;
        else if (r < 10) code = valid_codes[$urandom_range(0, 5)];
        else if (r == 10) code = 32'h05;
        else             code = $urandom | 32'h100;
        cycle();
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0; stallreq = 2'b00; code = 32'd0; epc = 32'd0; ebase = 32'd0;
        model_reset();
        @(posedge clk); #1;
        cycle(); cycle();

        // reset release, combinational stall
        rst_n = 1'b1;
        stallreq = 2'b01; #1;
        chk("stall_after_reset", st[0], 6'b000111);
        cycle();
        repeat (40) rand_cycle();

        // reset mid-flush
        stallreq = 2'b11; code = 32'h08; ebase = 32'h1000_0000;
        cycle();
        rst_n = 1'b0; #1;
        chk("rst_flush", fl[0], 1'b0);
        chk("rst_redirect", rd[0], 1'b0);
        chk("rst_new_pc", pc[0], 32'd0);
        chk("rst_stall", st[0], 6'd0);
        cycle();
        rst_n = 1'b1; stallreq = 2'b00; code = 32'd0;
        cycle();

        // watchdog
        stallreq = 2'b11; #1;
        chk("stall_both", st[0], 6'b001111);
        repeat (255) cycle();
        chk("timeout_not_yet", to[0], 1'b0);
        cycle();
        chk("timeout_set", to[0], 1'b1);
        stallreq = 2'b00;
        cycle(); cycle();
        chk("timeout_clear", to[0], 1'b0);

        // syscall with ebase
        ebase = 32'h8000_0000; stallreq = 2'b10; code = 32'h08; #1;
        chk("stall_killed_by_exc", st[0], 6'd0);
        cycle();
        chk("sys_flush", fl[0], 1'b1);
        chk("sys_redirect", rd[0], 1'b1);
        chk("sys_pc", pc[0], 32'h8000_0040);
        chk("sys_pc_f1", pc[1], 32'h8000_0040);
        code = 32'd0; stallreq = 2'b00;
        cycle(); chk("sys_flush2", fl[0], 1'b1);
        cycle(); chk("sys_flush3", fl[0], 1'b1);
        cycle(); chk("sys_flush_end", fl[0], 1'b0);

        // 3-cycle flush on interrupt, code during flush ignored
        code = 32'h01; cycle();
        chk("int_redirect", rd[0], 1'b1);
        chk("int_pc", pc[0], 32'h8000_0020);
        code = 32'h0c; cycle();
        chk("int_flush2", fl[0], 1'b1);
        chk("int_redirect2", rd[0], 1'b0);
        chk("int_pc2", pc[0], 32'h8000_0020);
        cycle();
        chk("int_flush3", fl[0], 1'b1);
        chk("int_pc3", pc[0], 32'h8000_0020);
        code = 32'd0; cycle();
        chk("int_flush_end", fl[0], 1'b0);
        chk("int_pc_hold", pc[0], 32'h8000_0020);

        // eret and an unknown code
        epc = 32'h0000_1234; code = 32'h0e; cycle();
        chk("eret_pc", pc[0], 32'h0000_1234);
        code = 32'd0; cycle(); cycle(); cycle();
        code = 32'h05; stallreq = 2'b01; #1;
        chk("bad_code_stall", st[0], 6'b000111);
        cycle();
        chk("bad_code_flush", fl[0], 1'b0);
        chk("bad_code_redirect", rd[0], 1'b0);
        code = 32'd0; stallreq = 2'b00; cycle();

        // back-to-back exceptions
        pulses = 0;
        code = 32'h08; cycle(); pulses += int'(rd[0]);
        code = 32'd0;
        repeat (3) begin cycle(); pulses += int'(rd[0]); end
        code = 32'h0d; cycle(); pulses += int'(rd[0]);
        chk("b2b_pc", pc[0], 32'h8000_0040);
        code = 32'd0;
        repeat (3) begin cycle(); pulses += int'(rd[0]); end
        chk("b2b_pulses", pulses, 2);

        repeat (600) rand_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
